debug_probe_arbiter: RTL and testbench

- Shares the four 80-bit ILA probe groups (5 x 16-bit triggers each) among NUM_REQ debug requesters, e.g. per-channel NAND controller debug buses.
- Round-robin grants free slots to requesters and holds each grant for a fixed capture window.
- Accepts per-slot pins and control bits from the VIO SYNC_OUT word, and returns status to VIO SYNC_IN.
- Sits between the controller debug buses and the chipscope debug wrapper.

---
 rtl/dbg_arb_pkg.sv | 29 ++
 rtl/debug_probe_arbiter_if.sv | 28 ++
 rtl/debug_rr_picker.sv | 33 +++
 rtl/debug_probe_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_debug_probe_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dbg_arb_pkg.sv
// Shared constants, VIO control field offsets and slot state encoding for the
// debug probe arbiter.
package dbg_arb_pkg;

    localparam int PROBE_W       = 80;
    localparam int VIO_W         = 64;
    localparam int CNT_W         = 16;

    localparam int ARB_EN_BIT    = 0;
    localparam int FREEZE_BIT    = 1;
    localparam int CLR_BIT       = 2;
    localparam int PIN_BASE      = 3;
    localparam int PIN_W         = 4;

    localparam int STAT_OWN_BASE = 4;
    localparam int STAT_OWN_W    = 3;
    localparam int STAT_CNT_BASE = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        PINNED = 2'd2
    } slot_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/debug_probe_arbiter_if.sv
// Requester, VIO and ILA-slot signal bundle between the debug buses, the
// arbiter and the chipscope wrapper.
interface debug_probe_arbiter_if #(
    parameter int NUM_REQ  = 8,
    parameter int NUM_SLOT = 4,
    parameter int REQ_W    = 3
);
    import dbg_arb_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*PROBE_W-1:0]  req_data;
    logic [VIO_W-1:0]            vio_ctrl;
    logic [NUM_SLOT*PROBE_W-1:0] slot_data;
    logic [NUM_SLOT*REQ_W-1:0]   slot_owner;
    logic [NUM_SLOT-1:0]         slot_busy;
    logic [VIO_W-1:0]            vio_status;

    modport master (
        output req_valid, req_data, vio_ctrl,
        input  slot_data, slot_owner, slot_busy, vio_status
    );

    modport slave (
        input  req_valid, req_data, vio_ctrl,
        output slot_data, slot_owner, slot_busy, vio_status
    );

endinterface

// File: rtl/debug_rr_picker.sv
// Rotating-priority picker: first eligible requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module debug_rr_picker #(
    parameter int NUM_REQ = 8,
    parameter int REQ_W   = 3
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [REQ_W-1:0]   rr_ptr,
    output logic               found,
    output logic [REQ_W-1:0]   winner
);
    localparam int            SW   = REQ_W + 1;
    localparam logic [SW-1:0] NREQ = SW'(NUM_REQ);

    logic [SW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + SW'(i);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eligible[idx[REQ_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[REQ_W-1:0];
            end
        end
    end

endmodule

// File: rtl/debug_probe_arbiter.sv
// Shares NUM_SLOT ILA probe groups among NUM_REQ debug requesters with
// round-robin grants, fixed capture windows and VIO pinning.
//
// state  | meaning
// IDLE   | slot free, slot_data forced to zero, grantable
// HOLD   | granted to a requester, hold counter running toward zero
// PINNED | forced to a requester by the VIO pin field
module debug_probe_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 8,
    parameter int NUM_SLOT    = 4,
    parameter int HOLD_CYCLES = 1024,
    parameter int REQ_W       = $clog2(NUM_REQ)
) (
    input logic                  v_clk0,
    input logic                  v_rst0,
    debug_probe_arbiter_if.slave bus
);
    localparam logic [1:0]       S_IDLE    = IDLE;
    localparam logic [1:0]       S_HOLD    = HOLD;
    localparam logic [1:0]       S_PINNED  = PINNED;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]                  state_q   [NUM_SLOT];
    logic [1:0]                  state_d   [NUM_SLOT];
    logic [REQ_W-1:0]            owner_q   [NUM_SLOT];
    logic [REQ_W-1:0]            owner_d   [NUM_SLOT];
    logic [CNT_W-1:0]            hold_q    [NUM_SLOT];
    logic [CNT_W-1:0]            hold_d    [NUM_SLOT];
    logic [REQ_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]            grant_cnt_q, grant_cnt_d;
    logic [NUM_SLOT*PROBE_W-1:0] slot_data_q, slot_data_d;

    logic                        arb_en, freeze, soft_clr;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_SLOT-1:0]         pin_act;
    logic [REQ_W-1:0]            pin_idx   [NUM_SLOT];
    logic [NUM_SLOT-1:0]         busy;
    logic [NUM_SLOT-1:0]         slot_free;
    logic [NUM_SLOT-1:0]         grant_oh;
    logic [NUM_REQ-1:0]          owned, pinned, eligible;
    logic                        pick_found, grant, taken;
    logic [REQ_W-1:0]            pick_idx;
    logic                        vio_unused;

    assign arb_en     = bus.vio_ctrl[ARB_EN_BIT];
    assign freeze     = bus.vio_ctrl[FREEZE_BIT];
    assign soft_clr   = bus.vio_ctrl[CLR_BIT];
    assign req_valid  = bus.req_valid;
    assign vio_unused = ^bus.vio_ctrl[VIO_W-1:PIN_BASE+PIN_W*NUM_SLOT];

    // An out-of-range pin index behaves exactly like pin_en = 0.
    for (genvar s = 0; s < NUM_SLOT; s++) begin : g_pin
        logic [PIN_W-1:0] fld;
        assign fld        = bus.vio_ctrl[PIN_BASE + PIN_W*s +: PIN_W];
        assign pin_act[s] = fld[PIN_W-1] && (int'(fld[2:0]) < NUM_REQ);
        assign pin_idx[s] = fld[REQ_W-1:0];
        assign busy[s]    = (state_q[s] != S_IDLE);
        assign slot_free[s] = (state_q[s] == S_IDLE) && !pin_act[s];
    end

    always_comb begin
        owned  = '0;
        pinned = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (busy[s]) owned[owner_q[s]] = 1'b1;
            if (pin_act[s]) pinned[pin_idx[s]] = 1'b1;
        end
    end

    assign eligible = req_valid & ~owned & ~pinned;

    debug_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .found    (pick_found),
        .winner   (pick_idx)
    );

    always_comb begin
        grant_oh = '0;
        taken    = 1'b0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (slot_free[s] && !taken) begin
                grant_oh[s] = 1'b1;
                taken       = 1'b1;
            end
        end
    end

    assign grant = arb_en && !freeze && !soft_clr && pick_found && taken;

    // Release checks use registered state, so a slot leaving HOLD sits in IDLE
    // for at least one cycle before it can be granted again.
    always_comb begin
        for (int s = 0; s < NUM_SLOT; s++) begin
            state_d[s] = state_q[s];
            owner_d[s] = owner_q[s];
            hold_d[s]  = hold_q[s];
            if (pin_act[s]) begin
                state_d[s] = S_PINNED;
                owner_d[s] = pin_idx[s];
                hold_d[s]  = '0;
            end else begin
                case (state_q[s])
                    S_IDLE: begin
                        if (grant && grant_oh[s]) begin
                            state_d[s] = S_HOLD;
                            owner_d[s] = pick_idx;
                            hold_d[s]  = HOLD_LOAD;
                        end
                    end
                    S_HOLD: begin
                        if (soft_clr || !arb_en || !req_valid[owner_q[s]] ||
                            (!freeze && hold_q[s] == '0)) begin
                            state_d[s] = S_IDLE;
                            owner_d[s] = '0;
                            hold_d[s]  = '0;
                        end else if (!freeze) begin
                            hold_d[s] = hold_q[s] - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[s] = S_IDLE;
                        owner_d[s] = '0;
                        hold_d[s]  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_cnt_d = grant_cnt_q;
        if (soft_clr) begin
            rr_ptr_d    = '0;
            grant_cnt_d = '0;
        end else if (grant) begin
            rr_ptr_d    = (pick_idx == REQ_W'(NUM_REQ - 1)) ? '0 : pick_idx + REQ_W'(1);
            grant_cnt_d = sat_inc(grant_cnt_q);
        end
    end

    always_comb begin
        slot_data_d = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (busy[s]) begin
                slot_data_d[s*PROBE_W +: PROBE_W] =
                    bus.req_data[int'(owner_q[s])*PROBE_W +: PROBE_W];
            end
        end
    end

    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) begin
            for (int s = 0; s < NUM_SLOT; s++) begin
                state_q[s] <= S_IDLE;
                owner_q[s] <= '0;
                hold_q[s]  <= '0;
            end
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
            slot_data_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOT; s++) begin
                state_q[s] <= state_d[s];
                owner_q[s] <= owner_d[s];
                hold_q[s]  <= hold_d[s];
            end
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
            slot_data_q <= slot_data_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOT; s++) begin : g_own
        assign bus.slot_owner[s*REQ_W +: REQ_W] = owner_q[s];
    end

    assign bus.slot_busy = busy;
    assign bus.slot_data = slot_data_q;

    always_comb begin
        bus.vio_status = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            bus.vio_status[s] = busy[s];
            bus.vio_status[STAT_OWN_BASE + STAT_OWN_W*s +: REQ_W] = owner_q[s];
        end
        bus.vio_status[STAT_CNT_BASE +: CNT_W] = grant_cnt_q;
    end

endmodule

// File: tb/tb_debug_probe_arbiter.sv
// Directed bench for debug_probe_arbiter with HOLD_CYCLES = 4 and
// hand-computed expected slot ownership, data and status.
module tb_debug_probe_arbiter;
    import dbg_arb_pkg::*;

    localparam int NR = 8;
    localparam int NS = 4;
    localparam int RW = 3;
    localparam int HC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic [NR*PROBE_W-1:0] prev_data;

    debug_probe_arbiter_if #(.NUM_REQ(NR), .NUM_SLOT(NS), .REQ_W(RW)) bus ();

    debug_probe_arbiter #(
        .NUM_REQ     (NR),
        .NUM_SLOT    (NS),
        .HOLD_CYCLES (HC),
        .REQ_W       (RW)
    ) dut (
        .v_clk0 (clk),
        .v_rst0 (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*PROBE_W-1:0] gen(input int c);
        logic [NR*PROBE_W-1:0] v;
        v = '0;
        for (int r = 0; r < NR; r++)
            v[r*PROBE_W +: PROBE_W] = {8'(r + 1), 8'hA5, 32'(c), 32'(r * 7 + c)};
        return v;
    endfunction

    function automatic logic [79:0] word(input logic [NR*PROBE_W-1:0] d, input int r);
        return d[r*PROBE_W +: PROBE_W];
    endfunction

    function automatic logic [63:0] mk_ctrl(input logic arb, input logic frz,
                                            input logic clr, input logic [15:0] pins);
        return {45'b0, pins, clr, frz, arb};
    endfunction

    function automatic logic [11:0] exp_owner(input logic [2:0] o0, input logic [2:0] o1,
                                              input logic [2:0] o2, input logic [2:0] o3);
        return {o3, o2, o1, o0};
    endfunction

    function automatic logic [63:0] exp_status(input logic [3:0] b, input logic [2:0] o0,
                                               input logic [2:0] o1, input logic [2:0] o2,
                                               input logic [2:0] o3, input logic [15:0] cnt);
        return {32'b0, cnt, o3, o2, o1, o0, b};
    endfunction

    task automatic tick();
        prev_data = bus.req_data;
        @(posedge clk);
        #1;
        cyc++;
        bus.req_data = gen(cyc);
    endtask

    task automatic do_reset();
        bus.vio_ctrl  = '0;
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_data  = gen(0);
        bus.vio_ctrl  = '0;
        prev_data     = '0;
        tick();
        tick();
        chk("rst_busy",   80'(bus.slot_busy),         80'(4'b0000));
        chk("rst_owner",  80'(bus.slot_owner),        80'(12'h000));
        chk("rst_data",   80'(bus.slot_data != '0),   80'(1'b0));
        chk("rst_status", 80'(bus.vio_status),        80'(64'h0));
        rst_n = 1'b1;

        // two requesters, two consecutive grants
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        bus.req_valid = 8'b0000_0101;
        tick();
        chk("s1_busy_t1",  80'(bus.slot_busy),  80'(4'b0001));
        chk("s1_owner_t1", 80'(bus.slot_owner), 80'(exp_owner(0, 0, 0, 0)));
        tick();
        chk("s1_busy_t2",   80'(bus.slot_busy),  80'(4'b0011));
        chk("s1_owner_t2",  80'(bus.slot_owner), 80'(exp_owner(0, 2, 0, 0)));
        chk("s1_status_t2", 80'(bus.vio_status), 80'(exp_status(4'b0011, 0, 2, 0, 0, 16'd2)));
        chk("s1_data0_t2",  bus.slot_data[0 +: 80],  word(prev_data, 0));
        chk("s1_data1_t2",  bus.slot_data[80 +: 80], 80'(0));

        // slots 1..3 pinned to 5,6,7; slot0 rotates between requesters 0 and 1
        do_reset();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'hFED0);
        bus.req_valid = 8'b0000_0011;
        tick();
        chk("s2_busy_t1",  80'(bus.slot_busy),  80'(4'b1111));
        chk("s2_owner_t1", 80'(bus.slot_owner), 80'(exp_owner(0, 5, 6, 7)));
        tick();
        tick();
        tick();
        chk("s2_hold_c4",  80'({bus.slot_busy[0], bus.slot_owner[2:0]}), 80'(4'b1_000));
        tick();
        chk("s2_idle_c5",  80'(bus.slot_busy[0]), 80'(1'b0));
        tick();
        chk("s2_rr_next",  80'({bus.slot_busy[0], bus.slot_owner[2:0]}), 80'(4'b1_001));
        chk("s2_gcnt",     80'(bus.vio_status[31:16]), 80'(16'd2));

        // early release by owner 3
        do_reset();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        bus.req_valid = 8'b0000_1000;
        tick();
        chk("s3_owner", 80'({bus.slot_busy, bus.slot_owner[2:0]}), 80'(7'b0001_011));
        tick();
        bus.req_valid = 8'b0000_0000;
        tick();
        chk("s3_busy_drop", 80'(bus.slot_busy), 80'(4'b0000));
        chk("s3_last_data", bus.slot_data[0 +: 80], word(prev_data, 3));
        tick();
        chk("s3_data_zero", bus.slot_data[0 +: 80], 80'(0));

        // pin slot2 to requester 5
        do_reset();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0D00);
        bus.req_valid = 8'b0000_0000;
        tick();
        chk("s4_pin_busy",  80'(bus.slot_busy),  80'(4'b0100));
        chk("s4_pin_owner", 80'(bus.slot_owner), 80'(exp_owner(0, 0, 5, 0)));
        tick();
        chk("s4_pin_data1", bus.slot_data[160 +: 80], word(prev_data, 5));
        bus.req_valid = 8'b0010_0000;
        tick();
        tick();
        chk("s4_no_regrant", 80'(bus.slot_busy), 80'(4'b0100));
        chk("s4_pin_data2",  bus.slot_data[160 +: 80], word(prev_data, 5));
        bus.vio_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("s4_unpin", 80'(bus.slot_busy), 80'(4'b0000));
        tick();
        chk("s4_regrant", 80'({bus.slot_busy, bus.slot_owner[2:0]}), 80'(7'b0001_101));

        // freeze with the hold counter at 2
        do_reset();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        bus.req_valid = 8'b0000_0001;
        tick();
        tick();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b1, 1'b0, 16'h0000);
        bus.req_valid = 8'b0000_0011;
        repeat (5) tick();
        chk("s5_frozen",      80'(bus.vio_status), 80'(exp_status(4'b0001, 0, 0, 0, 0, 16'd1)));
        bus.vio_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("s5_thaw_grant",  80'(bus.slot_busy), 80'(4'b0011));
        tick();
        chk("s5_still_held",  80'(bus.slot_busy[0]), 80'(1'b1));
        tick();
        chk("s5_release",     80'(bus.slot_busy[0]), 80'(1'b0));

        // build 3 busy slots with grant_cnt = 7, then soft_clr and async reset
        do_reset();
        bus.vio_ctrl  = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        bus.req_valid = 8'hFF;
        repeat (8) tick();
        chk("s6_pre_clr", 80'(bus.vio_status), 80'(exp_status(4'b0111, 4, 5, 6, 0, 16'd7)));
        bus.vio_ctrl = mk_ctrl(1'b1, 1'b0, 1'b1, 16'h0000);
        tick();
        chk("s6_clr", 80'(bus.vio_status), 80'(exp_status(4'b0000, 0, 0, 0, 0, 16'd0)));
        bus.vio_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        chk("s6_rr_reset", 80'(bus.vio_status), 80'(exp_status(4'b0001, 0, 0, 0, 0, 16'd1)));
        tick();
        chk("s6_pre_rst", 80'(bus.slot_busy), 80'(4'b0011));
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_async_busy",   80'(bus.slot_busy),       80'(4'b0000));
        chk("s6_async_status", 80'(bus.vio_status),      80'(64'h0));
        chk("s6_async_data",   80'(bus.slot_data != '0), 80'(1'b0));
        chk("s6_async_owner",  80'(bus.slot_owner),      80'(12'h000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
